// File: rtl/dot_matrix_scanner_pkg.sv
// Shared definitions for the 16x16 LED dot-matrix scanner.
//   ROWS/COLS : matrix geometry
//   ROW_W     : width of the row index driven to the pattern ROM
//   state_e   : scanner sequencing states
//   ROW_OFF   : row_sel value with every row released (active-low drive)
package dot_matrix_pkg;

  localparam int unsigned ROWS  = 16;
  localparam int unsigned COLS  = 16;
  localparam int unsigned ROW_W = 4;

  localparam logic [ROWS-1:0] ROW_OFF = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    LOAD  = 2'd2,
    SHOW  = 2'd3
  } state_e;

endpackage

// File: rtl/dot_matrix_scanner_row_onehot_dec.sv
// 4-to-16 active-low one-hot row decoder with enable.
//   row_i   : row index to drive low
//   en_i    : 0 releases every row (all ones)
//   sel_n_o : active-low one-hot row select (combinational)
module row_onehot_dec
  import dot_matrix_pkg::*;
(
  input  logic [ROW_W-1:0] row_i,
  input  logic             en_i,
  output logic [ROWS-1:0]  sel_n_o
);

  assign sel_n_o = en_i ? ~(ROWS'(1) << row_i) : ROW_OFF;

endmodule

// File: rtl/dot_matrix_scanner.sv
// Row-at-a-time scanner for a 16x16 LED dot matrix fed by an external
// combinational pattern ROM. Each row: BLANK_CYCLES off, one LOAD cycle
// that samples the ROM word, then SHOW_CYCLES lit.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   en         : scan enable; 0 parks the scanner in IDLE with outputs off
//   col_in     : ROM column word for row_bin
//   row_bin    : row index presented to the ROM (registered)
//   row_sel    : active-low one-hot row drive (registered)
//   col_out    : active-high column drive, bit 15 leftmost (registered)
//   frame_done : one-cycle pulse after row 15 finishes SHOW (registered)
module dot_matrix_scanner
  import dot_matrix_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES  = 4,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [COLS-1:0]  col_in,
  output logic [ROW_W-1:0] row_bin,
  output logic [ROWS-1:0]  row_sel,
  output logic [COLS-1:0]  col_out,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ROW_W-1:0] row_bin_q;
  logic [ROWS-1:0]  row_sel_q;
  // col_out_q doubles as the captured row word: it only ever holds the
  // LOAD sample or zero, so no separate column register is needed.
  logic [COLS-1:0]  col_out_q;
  logic             frame_done_q;

  logic             lit_d;
  logic [ROWS-1:0]  row_sel_d;

  // Row is lit in the next cycle when leaving LOAD or continuing SHOW.
  assign lit_d = en && ((state_q == LOAD) ||
                        ((state_q == SHOW) && (cnt_q != SHOW_LAST)));

  row_onehot_dec u_dec (
    .row_i   (row_bin_q),
    .en_i    (lit_d),
    .sel_n_o (row_sel_d)
  );

  // Scanner sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      row_bin_q    <= '0;
      row_sel_q    <= ROW_OFF;
      col_out_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      row_sel_q    <= row_sel_d;
      case (state_q)
        IDLE: begin
          state_q   <= BLANK;
          cnt_q     <= '0;
          col_out_q <= '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_q <= LOAD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LOAD: begin
          col_out_q <= col_in;
          state_q   <= SHOW;
          cnt_q     <= '0;
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            col_out_q    <= '0;
            row_bin_q    <= row_bin_q + ROW_W'(1);
            frame_done_q <= (row_bin_q == ROW_LAST);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign row_bin    = row_bin_q;
  assign row_sel    = row_sel_q;
  assign col_out    = col_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Self-checking bench for dot_matrix_scanner against a timeline model:
// the scan is tracked as elapsed cycles since the scan started, and row,
// phase and frame boundaries fall out of division by the row period.
module tb_dot_matrix_scanner;

  localparam int SHOW  = 4;
  localparam int BLANK = 2;
  localparam int RP    = BLANK + 1 + SHOW;
  localparam int FP    = 16 * RP;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] col_in;
  logic [3:0]  row_bin;
  logic [15:0] row_sel;
  logic [15:0] col_out;
  logic        frame_done;

  always #5 clk = ~clk;

  dot_matrix_scanner #(
    .SHOW_CYCLES  (SHOW),
    .BLANK_CYCLES (BLANK),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .col_in     (col_in),
    .row_bin    (row_bin),
    .row_sel    (row_sel),
    .col_out    (col_out),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;

  // Reference model: active flag, cycles since scan start, captured word.
  bit          m_act = 1'b0;
  int          m_t   = 0;
  logic [15:0] m_col = 16'h0000;

  function automatic logic [15:0] rom(input logic [3:0] r);
    logic [15:0] v;
    if (r == 4'd1) v = 16'h0C00;
    else           v = 16'((32'(r) + 1) * 32'h1357) ^ 16'h0F0F;
    return v;
  endfunction

  function automatic int m_row();
    return m_act ? (m_t / RP) % 16 : 0;
  endfunction

  function automatic bit m_lit();
    return m_act && ((m_t % RP) >= BLANK + 1);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  // cmode 0: ROM; 1: random noise; 2: ROM but FFFF while a row is lit.
  task automatic step(input logic r, input logic e, input int cmode);
    logic [15:0] cv;
    logic [15:0] one;
    logic [15:0] exp_sel;
    case (cmode)
      1:       cv = 16'($urandom);
      2:       cv = m_lit() ? 16'hFFFF : rom(row_bin);
      default: cv = rom(row_bin);
    endcase
    rst = r; en = e; col_in = cv;
    @(posedge clk);
    if (r || !e) begin
      m_act = 1'b0;
      m_t   = 0;
    end else if (!m_act) begin
      m_act = 1'b1;
      m_t   = 0;
    end else begin
      m_t++;
      if ((m_t % RP) == BLANK + 1) m_col = cv;
    end
    #1;
    one     = 16'h0001;
    exp_sel = m_lit() ? ~(one << m_row()) : 16'hFFFF;
    if (frame_done === 1'b1) n_frames++;
    chk("row_bin", 16'(row_bin), 16'(m_row()));
    chk("row_sel", row_sel, exp_sel);
    chk("col_out", col_out, m_lit() ? m_col : 16'h0000);
    chk("frame_done", 16'(frame_done),
        16'(m_act && m_t > 0 && (m_t % FP) == 0));
  endtask

  initial begin
    int guard;
    rst = 1'b1; en = 1'b1; col_in = 16'h0000;

    // Reset held two cycles with en high.
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b1, 0);

    // Two full frames from the ROM.
    n_frames = 0;
    repeat (2 * FP + 1) step(1'b0, 1'b1, 0);
    chk("frame_count", 16'(n_frames), 16'd2);

    // col_in noise and FFFF during SHOW must not reach col_out.
    repeat (120) step(1'b0, 1'b1, 1);
    repeat (120) step(1'b0, 1'b1, 2);

    // Drop en in the middle of row 9 SHOW.
    guard = 0;
    while (!(m_act && m_row() == 9 && (m_t % RP) == BLANK + 2) && guard < 2 * FP) begin
      step(1'b0, 1'b1, 0);
      guard++;
    end
    chk("reach_row9", 16'(guard < 2 * FP), 16'd1);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1);
    repeat (20) step(1'b0, 1'b1, 0);

    // Reset during BLANK of row 15.
    guard = 0;
    while (!(m_act && m_row() == 15 && (m_t % RP) == 0) && guard < 2 * FP) begin
      step(1'b0, 1'b1, 0);
      guard++;
    end
    chk("reach_row15", 16'(guard < 2 * FP), 16'd1);
    step(1'b1, 1'b1, 0);
    repeat (20) step(1'b0, 1'b1, 0);

    // Randomized enable drops, resets and column noise.
    for (int i = 0; i < 800; i++) begin
      step(1'(($urandom % 97) == 0), 1'(($urandom % 41) != 0), int'($urandom % 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_matrix_scanner.md
Name: dot_matrix_scanner

Overview:
- Consumer side of the 16x16 LED dot-matrix pattern ROMs used by the traffic-light display.
- Drives `row_bin` into a combinational pattern ROM and samples the returned 16-bit `col` word.
- Drives the matrix row-select lines (active-low, one-hot) and column lines, one row at a time.
- Inserts a blanking gap between rows to prevent ghosting, and flags completion of each frame.

Parameters:
- SHOW_CYCLES, 4, clk cycles each row is lit; must be >= 1.
- BLANK_CYCLES, 2, clk cycles all rows are off before each row; must be >= 1.
- CNT_W, 16, width of the phase counter; must hold max(SHOW_CYCLES, BLANK_CYCLES) - 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  scan enable; 0 blanks the display and parks the scanner.
- col_in  input  16  pattern word from the ROM for the current `row_bin`.
- row_bin  output  4  row index presented to the ROM (registered).
- row_sel  output  16  matrix row drive, active-low one-hot; bit i is row i.
- col_out  output  16  matrix column drive, active-high; bit 15 is the leftmost column.
- frame_done  output  1  one-cycle pulse when row 15 finishes SHOW.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high: `rst` is sampled on the clk rising edge.
  - On reset: state=IDLE, row_bin=0, row_sel=16'hFFFF, col_out=16'h0000, frame_done=0, phase counter=0.
  - Reset asserted mid-row discards the row with no partial SHOW. The next frame starts at row 0.
- All outputs are registered.
- State machine: IDLE, BLANK, LOAD, SHOW.
  - IDLE: outputs off (row_sel=FFFF, col_out=0), row_bin=0. If en=1, go to BLANK next cycle with counter=0.
  - BLANK: outputs off, row_bin held stable.
    - Stays exactly BLANK_CYCLES cycles; the counter counts 0..BLANK_CYCLES-1, then LOAD.
  - LOAD: exactly one cycle, outputs still off.
    - At the end of the cycle, col_in is captured into the internal col_reg.
    - Next state is SHOW with counter=0.
  - SHOW: row_sel = ~(16'h1 << row_bin), col_out = col_reg.
    - row_sel and col_out update together on the first SHOW cycle.
    - Stays exactly SHOW_CYCLES cycles.
    - On the last cycle, the next edge does row_bin <= row_bin + 1 (4-bit wrap 15 -> 0), state <= BLANK, outputs <= off.
    - If row_bin was 15, frame_done is 1 for the single cycle that follows (the first BLANK cycle of row 0).
- col_in is sampled only in LOAD. Changes to col_in in any other state have no effect on col_out.
- Row period = BLANK_CYCLES + 1 + SHOW_CYCLES cycles. Frame period = 16 x row period.
  - Example: defaults give 7 and 112 cycles.
- en deasserted in any non-IDLE state:
  - Next edge goes to IDLE, blanks outputs, row_bin <= 0, frame_done stays 0 (even if row 15 was mid-SHOW).
- en reasserted: restarts at BLANK of row 0.
- rst has priority over en.
- row_sel never has more than one low bit. It is never low in the same cycle that col_out changes from one row's data to another's.

Decomposition:
- Package dot_matrix_pkg holds:
  - ROWS=16 and COLS=16;
  - ROW_W=4;
  - the state enum {IDLE, BLANK, LOAD, SHOW};
  - the constant ROW_OFF=16'hFFFF.
- One sub-module is natural: row_onehot_dec, a 4-to-16 active-low one-hot decoder with an enable; enable=0 gives FFFF.
- The pattern ROMs stay external and connect via row_bin/col_in.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1 -> row_sel=FFFF, col_out=0, row_bin=0, frame_done=0. Release -> first SHOW of row 0 begins at cycle 3 after release (2 BLANK + 1 LOAD).
- Single row: ROM model returns 16'h0C00 for row 1 -> row 1 SHOW shows row_sel=16'hFFFD and col_out=0C00 for exactly 4 cycles, bracketed by 3 off cycles.
- Full frame: en=1 with the traffic-figure ROM model -> row_bin walks 0..15; frame_done pulses once every 112 cycles; the scoreboard matches all 16 col words.
- Sampling: toggle col_in to 16'hFFFF during SHOW of row 5 -> col_out stays at the value captured in LOAD.
- Enable drop: en=0 mid-SHOW of row 9 -> next cycle row_sel=FFFF, col_out=0, row_bin=0, no frame_done. en=1 -> restarts at row 0.
- Reset mid-row: rst=1 during BLANK of row 15 -> IDLE with no frame_done pulse. Release with en=1 -> row 0 SHOW begins after 3 cycles.
